// File: rtl/serial_addr.sv
`default_nettype none
// ============================================================================
// Module   : serial_addr (with full_addr bit cell)
// Brief    : Bit-serial WIDTH-bit adder, LSB first, start/busy/done handshake.
// Revision : 1.0  initial release
// ============================================================================

module full_addr (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic sum,
    output logic carry
);
    assign sum   = a ^ b ^ ci;
    assign carry = (a & b) | (ci & (a ^ b));
endmodule

module serial_addr #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             co
);
    localparam int                  c_CNT_W = $clog2(WIDTH + 1);
    localparam logic [c_CNT_W-1:0]  c_LAST  = c_CNT_W'(WIDTH - 1);
    localparam logic [c_CNT_W-1:0]  c_ONE   = c_CNT_W'(1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_SHIFT = 2'd1;
    localparam logic [1:0] c_DONE  = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic [WIDTH-1:0]   r_sa;
    logic [WIDTH-1:0]   r_sb;
    logic [WIDTH-1:0]   r_sr;
    logic               r_c;
    logic [c_CNT_W-1:0] r_cnt;

    logic               w_bit_sum;
    logic               w_bit_carry;
    logic               w_accept;
    logic               w_last;
    logic [WIDTH:0]     w_sr_cat;
    logic [WIDTH-1:0]   w_sr_next;

    full_addr u_cell (
        .a     (r_sa[0]),
        .b     (r_sb[0]),
        .ci    (r_c),
        .sum   (w_bit_sum),
        .carry (w_bit_carry)
    );

    // New sum bit enters at the MSB; concatenation keeps WIDTH=1 legal.
    assign w_sr_cat  = {w_bit_sum, r_sr};
    assign w_sr_next = w_sr_cat[WIDTH:1];
    assign w_accept  = start && (r_state != c_SHIFT);
    assign w_last    = (r_cnt == c_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:  if (start) w_next_state = c_SHIFT;
            c_SHIFT: if (w_last) w_next_state = c_DONE;
            c_DONE:  w_next_state = start ? c_SHIFT : c_IDLE;
            default: w_next_state = c_IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            c_SHIFT: busy = 1'b1;
            c_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sa  <= '0;
            r_sb  <= '0;
            r_sr  <= '0;
            r_c   <= 1'b0;
            r_cnt <= '0;
            sum   <= '0;
            co    <= 1'b0;
        end else if (w_accept) begin
            r_sa  <= a;
            r_sb  <= b;
            r_c   <= ci;
            r_cnt <= '0;
        end else if (r_state == c_SHIFT) begin
            r_sa  <= r_sa >> 1;
            r_sb  <= r_sb >> 1;
            r_sr  <= w_sr_next;
            r_c   <= w_bit_carry;
            r_cnt <= r_cnt + c_ONE;
            if (w_last) begin
                sum <= w_sr_next;
                co  <= w_bit_carry;
            end
        end
    end
endmodule

`default_nettype wire

// File: doc/serial_addr.md
# serial_addr

Bit-serial N-bit adder built around the one-bit `full_addr` cell. It performs `a + b + ci` one bit per clock, LSB first. The `full_addr` cell does the per-bit add, and a carry flip-flop closes the loop between bits. The block sits between operand registers and any consumer that wants a multi-bit sum at low area cost. The start/busy/done handshake lets a controller or bench sequence operations.

## Interface
- `WIDTH`, default 8: operand and sum width in bits; legal range WIDTH >= 1.
- `clk`  in  1: single clock; all state updates on its rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `start`  in  1: request to begin an add; sampled only when `busy`=0.
- `a`  in  WIDTH: operand A; captured on the accepted `start` edge.
- `b`  in  WIDTH: operand B; captured on the accepted `start` edge.
- `ci`  in  1: carry-in; captured on the accepted `start` edge.
- `busy`  out  1: high while bits are being processed.
- `done`  out  1: single-cycle pulse when `sum`/`co` become valid.
- `sum`  out  WIDTH: result, registered, held until the next completion.
- `co`  out  1: carry-out of bit WIDTH-1, registered, held like `sum`.

## Operation
- Internal state:
  - shift registers `sa` and `sb` (WIDTH each)
  - carry flip-flop `c`
  - result shift register `sr` (WIDTH)
  - bit counter `cnt`, width clog2(WIDTH+1)
  - FSM with states IDLE, SHIFT, DONE
- The bit cell is one `full_addr` instance with ports in order (a, b, ci, sum, carry), fed by `sa[0]`, `sb[0]` and `c`.
- IDLE: `busy`=0, `done`=0. When `start`=1:
  - load `sa`←`a`, `sb`←`b`, `c`←`ci`, `cnt`←0
  - go to SHIFT
- SHIFT: `busy`=1. On each edge:
  - `sr` shifts right with the cell sum entering at the MSB
  - `sa` and `sb` shift right with zero fill
  - `c`←cell carry
  - `cnt`←`cnt`+1
- When `cnt` reaches WIDTH-1 on an edge, i.e. the WIDTH-th shift:
  - `sum`←final `sr` value (including the current sum bit)
  - `co`←cell carry
  - go to DONE
- DONE: `busy`=0, `done`=1 for exactly one cycle.
  - If `start`=1 in this cycle, it is accepted exactly as in IDLE and the next state is SHIFT.
  - Otherwise the next state is IDLE.
- `start` while `busy`=1 is ignored. Operands are not re-sampled and the in-flight result is unaffected.
- `a`, `b`, `ci` are don't-care except on the accepted `start` edge.
- `sum`/`co` change only on the completion edge. They never expose partial results.
- Arithmetic: {`co`,`sum`} = `a` + `b` + `ci`, modulo 2^(WIDTH+1), unsigned. `co` is the true carry-out; there is no overflow flag.

## Timing
- Reset (`reset`=1 at a rising edge) puts the FSM in IDLE and clears `busy`=0, `done`=0, `sum`=0, `co`=0, `sa`, `sb`, `c`, `sr` and `cnt`. Reset takes priority over `start`.
- Reset mid-SHIFT aborts the operation:
  - no `done` pulse
  - `sum`/`co` are cleared to 0, not left at the old result
- Latency, with the accepted start edge as E0:
  - `busy`=1 in the cycles after E0 through E(WIDTH-1)
  - the completion edge is E(WIDTH)
  - `done`=1 and valid `sum`/`co` appear in the cycle after E(WIDTH)
- Throughput: one add per WIDTH+1 cycles when `start` is held high, because DONE accepts a new start.
- WIDTH=1: a single SHIFT cycle; the same rules apply.

## Test plan
- WIDTH=8, `a`=0x5A, `b`=0x3C, `ci`=0, pulse `start` → `busy` is high for 8 cycles, then `done` pulses once with `sum`=0x96, `co`=0.
- WIDTH=8, `a`=0xFF, `b`=0x01, `ci`=0 → `sum`=0x00, `co`=1. Then `a`=0xFF, `b`=0xFF, `ci`=1 → `sum`=0xFF, `co`=1.
- Change `a`/`b` and pulse `start` during SHIFT → ignored. Result equals the originally captured operands and there is exactly one `done` pulse.
- Hold `start`=1 with a new operand pair (0x10+0x20, `ci`=1) presented in the DONE cycle → first result held, second `done` after 9 more cycles with `sum`=0x31, `co`=0.
- Assert `reset` 3 cycles into SHIFT → next cycle `busy`=0, `sum`=0, `co`=0, and no `done` pulse ever follows.
- WIDTH=2, exhaustive: nested loops over all `a`, `b`, `ci` (32 cases), each started and waited to `done` → {`co`,`sum`} == `a`+`b`+`ci` every case.
